bcd_add_datapath: RTL and testbench

Responder end of the BCD add command interface. It accepts the one-hot request strobes issued by the lab-2 controller (init, load A/B, display A/B, add, display result LS/MS) and performs each operation on two-digit BCD operands taken from the switch bank. It drives the 8-bit display value and returns one acknowledge per request using a four-phase handshake. It sits between the controller and the board switch/LED/seven-segment I/O.

---
 rtl/bcd_pkg.sv | 31 +++
 rtl/bcd_digit_add.sv | 26 ++
 rtl/bcd_add_datapath.sv | 177 +++++++++++++++++
 tb/tb_bcd_add_datapath.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the two-digit BCD add datapath.
// The command enum order is also the request priority order (lowest value wins).
package bcd_pkg;

    localparam int          BCD_DIGIT_W   = 4;
    localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_ADD_LO,
        ST_ADD_HI,
        ST_ACK
    } bcd_state_e;

    typedef enum logic [2:0] {
        CMD_INIT              = 3'd0,
        CMD_LOAD_A            = 3'd1,
        CMD_LOAD_B            = 3'd2,
        CMD_ADD               = 3'd3,
        CMD_DISPLAY_A         = 3'd4,
        CMD_DISPLAY_B         = 3'd5,
        CMD_DISPLAY_RESULT_MS = 3'd6,
        CMD_DISPLAY_RESULT_LS = 3'd7
    } bcd_cmd_e;

    function automatic logic [BCD_DIGIT_W-1:0] bcd_sat(input logic [BCD_DIGIT_W-1:0] d);
        return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single BCD digit adder: digit + digit + carry-in -> digit, carry-out.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] sum,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] bin_sum;

    // Non-BCD inputs are not rejected here; they simply follow the +6 rule.
    always_comb begin
        bin_sum = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
        if (bin_sum > {1'b0, BCD_MAX_DIGIT}) begin
            sum  = bin_sum[BCD_DIGIT_W-1:0] + 4'd6;
            cout = 1'b1;
        end else begin
            sum  = bin_sum[BCD_DIGIT_W-1:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_add_datapath.sv
// Four-phase responder for the BCD add command interface (load/display/add/init).
// Define BCD_INPUT_CHECK_EN to saturate non-BCD switch digits on load and raise sticky ERR.
module bcd_add_datapath
    import bcd_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] SW,
    input  logic       BCD_INIT,
    input  logic       BCD_LOAD_A,
    input  logic       BCD_LOAD_B,
    input  logic       BCD_DISPLAY_A,
    input  logic       BCD_DISPLAY_B,
    input  logic       BCD_ADD,
    input  logic       BCD_DISPLAY_RESULT_LS,
    input  logic       BCD_DISPLAY_RESULT_MS,
    output logic       BCD_INIT_ACK,
    output logic       BCD_LOAD_A_ACK,
    output logic       BCD_LOAD_B_ACK,
    output logic       BCD_DISPLAY_A_ACK,
    output logic       BCD_DISPLAY_B_ACK,
    output logic       BCD_ADD_ACK,
    output logic       BCD_DISPLAY_RESULT_LS_ACK,
    output logic       BCD_DISPLAY_RESULT_MS_ACK,
    output logic [7:0] DISP,
    output logic       ERR
);

    bcd_state_e  state_q, state_d;
    bcd_cmd_e    cmd_q, cmd_d, win;
    logic [7:0]  a_q, a_d, b_q, b_d, disp_q, disp_d;
    logic [11:0] r_q, r_d;
    logic        carry_q, carry_d;
    logic [7:0]  req, ack_vec, sw_store;
    logic        sw_bad;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    // Bit position equals the command enum value.
    assign req = {BCD_DISPLAY_RESULT_LS, BCD_DISPLAY_RESULT_MS, BCD_DISPLAY_B, BCD_DISPLAY_A,
                  BCD_ADD, BCD_LOAD_B, BCD_LOAD_A, BCD_INIT};

    always_comb begin
        win = CMD_INIT;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) win = bcd_cmd_e'(i[2:0]);
        end
    end

`ifdef BCD_INPUT_CHECK_EN
    logic err_q, err_d;
    assign sw_store = {bcd_sat(SW[7:4]), bcd_sat(SW[3:0])};
    assign sw_bad   = (SW[7:4] > BCD_MAX_DIGIT) || (SW[3:0] > BCD_MAX_DIGIT);
    assign ERR      = err_q;
`else
    assign sw_store = SW;
    assign sw_bad   = 1'b0;
    assign ERR      = 1'b0;
`endif

    // One adder serves both digit phases; ADD_LO feeds the ones digits with no carry-in.
    assign add_a   = (state_q == ST_ADD_LO) ? a_q[3:0] : a_q[7:4];
    assign add_b   = (state_q == ST_ADD_LO) ? b_q[3:0] : b_q[7:4];
    assign add_cin = (state_q == ST_ADD_LO) ? 1'b0     : carry_q;

    bcd_digit_add u_digit_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        disp_d  = disp_q;
        carry_d = carry_q;
`ifdef BCD_INPUT_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    cmd_d   = win;
                    state_d = (win == CMD_ADD) ? ST_ADD_LO : ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cmd_q)
                    CMD_INIT: begin
                        a_d    = 8'h00;
                        b_d    = 8'h00;
                        r_d    = 12'h000;
                        disp_d = 8'h00;
`ifdef BCD_INPUT_CHECK_EN
                        err_d  = 1'b0;
`endif
                    end
                    CMD_LOAD_A: begin
                        a_d = sw_store;
`ifdef BCD_INPUT_CHECK_EN
                        err_d = err_q | sw_bad;
`endif
                    end
                    CMD_LOAD_B: begin
                        b_d = sw_store;
`ifdef BCD_INPUT_CHECK_EN
                        err_d = err_q | sw_bad;
`endif
                    end
                    CMD_DISPLAY_A:         disp_d = a_q;
                    CMD_DISPLAY_B:         disp_d = b_q;
                    CMD_DISPLAY_RESULT_LS: disp_d = r_q[7:0];
                    CMD_DISPLAY_RESULT_MS: disp_d = {4'h0, r_q[11:8]};
                    default: ;
                endcase
                state_d = ST_ACK;
            end
            ST_ADD_LO: begin
                r_d[3:0] = add_sum;
                carry_d  = add_cout;
                state_d  = ST_ADD_HI;
            end
            ST_ADD_HI: begin
                r_d     = {3'b000, add_cout, add_sum, r_q[3:0]};
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!req[cmd_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_INIT;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            r_q     <= 12'h000;
            disp_q  <= 8'h00;
            carry_q <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            disp_q  <= disp_d;
            carry_q <= carry_d;
`ifdef BCD_INPUT_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign ack_vec = (state_q == ST_ACK) ? (8'b1 << cmd_q) : 8'b0;
    assign DISP    = disp_q;

    assign BCD_INIT_ACK              = ack_vec[CMD_INIT];
    assign BCD_LOAD_A_ACK            = ack_vec[CMD_LOAD_A];
    assign BCD_LOAD_B_ACK            = ack_vec[CMD_LOAD_B];
    assign BCD_ADD_ACK               = ack_vec[CMD_ADD];
    assign BCD_DISPLAY_A_ACK         = ack_vec[CMD_DISPLAY_A];
    assign BCD_DISPLAY_B_ACK         = ack_vec[CMD_DISPLAY_B];
    assign BCD_DISPLAY_RESULT_MS_ACK = ack_vec[CMD_DISPLAY_RESULT_MS];
    assign BCD_DISPLAY_RESULT_LS_ACK = ack_vec[CMD_DISPLAY_RESULT_LS];

endmodule

// File: tb/tb_bcd_add_datapath.sv
// Bench for bcd_add_datapath: decimal reference model, DISP scoreboard, handshake timing checks.
module tb_bcd_add_datapath;

    localparam int C_INIT = 0, C_LOAD_A = 1, C_LOAD_B = 2, C_ADD = 3,
                   C_DISP_A = 4, C_DISP_B = 5, C_DISP_MS = 6, C_DISP_LS = 7;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] SW = 8'h00;
    logic [7:0] req = 8'h00;
    logic [7:0] ack;
    logic [7:0] DISP;
    logic       ERR;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  a_m = 8'h00, b_m = 8'h00, disp_m = 8'h00;
    logic [11:0] r_m = 12'h000;
    logic        err_m = 1'b0;

    always #5 CLK = ~CLK;

    bcd_add_datapath dut (
        .CLK                       (CLK),
        .RST_N                     (RST_N),
        .SW                        (SW),
        .BCD_INIT                  (req[C_INIT]),
        .BCD_LOAD_A                (req[C_LOAD_A]),
        .BCD_LOAD_B                (req[C_LOAD_B]),
        .BCD_DISPLAY_A             (req[C_DISP_A]),
        .BCD_DISPLAY_B             (req[C_DISP_B]),
        .BCD_ADD                   (req[C_ADD]),
        .BCD_DISPLAY_RESULT_LS     (req[C_DISP_LS]),
        .BCD_DISPLAY_RESULT_MS     (req[C_DISP_MS]),
        .BCD_INIT_ACK              (ack[C_INIT]),
        .BCD_LOAD_A_ACK            (ack[C_LOAD_A]),
        .BCD_LOAD_B_ACK            (ack[C_LOAD_B]),
        .BCD_DISPLAY_A_ACK         (ack[C_DISP_A]),
        .BCD_DISPLAY_B_ACK         (ack[C_DISP_B]),
        .BCD_ADD_ACK               (ack[C_ADD]),
        .BCD_DISPLAY_RESULT_LS_ACK (ack[C_DISP_LS]),
        .BCD_DISPLAY_RESULT_MS_ACK (ack[C_DISP_MS]),
        .DISP                      (DISP),
        .ERR                       (ERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sat_ref(input logic [3:0] d);
`ifdef BCD_INPUT_CHECK_EN
        return (d > 4'd9) ? 4'd9 : d;
`else
        return d;
`endif
    endfunction

    // Reference add done in decimal integers; valid only for BCD operands.
    function automatic logic [11:0] add_ref(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'(a[7:4]) * 10 + int'(a[3:0]) + int'(b[7:4]) * 10 + int'(b[3:0]);
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic model_cmd(input int win, input logic [7:0] sw);
        logic bad;
        bad = (sw[7:4] > 4'd9) || (sw[3:0] > 4'd9);
        case (win)
            C_INIT:    begin a_m = 0; b_m = 0; r_m = 0; disp_m = 0; err_m = 0; end
            C_LOAD_A:  begin a_m = {sat_ref(sw[7:4]), sat_ref(sw[3:0])};
`ifdef BCD_INPUT_CHECK_EN
                             err_m = err_m | bad;
`endif
                       end
            C_LOAD_B:  begin b_m = {sat_ref(sw[7:4]), sat_ref(sw[3:0])};
`ifdef BCD_INPUT_CHECK_EN
                             err_m = err_m | bad;
`endif
                       end
            C_ADD:     r_m = add_ref(a_m, b_m);
            C_DISP_A:  disp_m = a_m;
            C_DISP_B:  disp_m = b_m;
            C_DISP_MS: disp_m = {4'h0, r_m[11:8]};
            default:   disp_m = r_m[7:0];
        endcase
        exp_q.push_back(disp_m);
    endtask

    // Raise the request mask, wait for the acknowledge, hold a while, then release.
    task automatic run_cmd(input logic [7:0] mask, input int win, input logic [7:0] sw);
        int lat, hold;
        logic [7:0] exp_ack;
        @(negedge CLK);
        SW  = sw;
        req = mask;
        model_cmd(win, sw);
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
        end while (ack == 8'h00 && lat < 20);
        check("ack_latency", lat, (win == C_ADD) ? 3 : 2);
        exp_ack = 8'b1 << win;
        check("ack_onehot", ack, exp_ack);
        check("disp", DISP, exp_q.pop_front());
        check("err", ERR, err_m);
        @(negedge CLK);
        SW = 8'($urandom_range(0, 255));
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            check("ack_hold", ack, exp_ack);
        end
        @(negedge CLK);
        req = 8'h00;
        @(posedge CLK); #1;
        check("ack_fall", ack, 8'h00);
    endtask

    initial begin
        logic [7:0] ra, rb;
        #1;
        check("rst_ack", ack, 8'h00);
        check("rst_disp", DISP, 8'h00);
        check("rst_err", ERR, 1'b0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;

        run_cmd(8'h01 << C_INIT, C_INIT, 8'h00);
        run_cmd(8'h01 << C_LOAD_A, C_LOAD_A, 8'h47);
        run_cmd(8'h01 << C_LOAD_B, C_LOAD_B, 8'h85);
        run_cmd(8'h01 << C_DISP_A, C_DISP_A, 8'h00);
        run_cmd(8'h01 << C_DISP_B, C_DISP_B, 8'h00);
        run_cmd(8'h01 << C_ADD, C_ADD, 8'h00);
        run_cmd(8'h01 << C_DISP_LS, C_DISP_LS, 8'h00);
        run_cmd(8'h01 << C_DISP_MS, C_DISP_MS, 8'h00);

        run_cmd(8'h01 << C_LOAD_A, C_LOAD_A, 8'h99);
        run_cmd(8'h01 << C_LOAD_B, C_LOAD_B, 8'h99);
        run_cmd(8'h01 << C_ADD, C_ADD, 8'h00);
        run_cmd(8'h01 << C_DISP_MS, C_DISP_MS, 8'h00);
        run_cmd(8'h01 << C_DISP_LS, C_DISP_LS, 8'h00);

        run_cmd(8'h01 << C_LOAD_A, C_LOAD_A, 8'h00);
        run_cmd(8'h01 << C_LOAD_B, C_LOAD_B, 8'h00);
        run_cmd(8'h01 << C_ADD, C_ADD, 8'h00);
        run_cmd(8'h01 << C_DISP_MS, C_DISP_MS, 8'h00);
        run_cmd(8'h01 << C_DISP_LS, C_DISP_LS, 8'h00);

        for (int k = 0; k < 6; k++) begin
            ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            run_cmd(8'h01 << C_LOAD_A, C_LOAD_A, ra);
            run_cmd(8'h01 << C_LOAD_B, C_LOAD_B, rb);
            run_cmd(8'h01 << C_ADD, C_ADD, 8'h00);
            run_cmd(8'h01 << C_DISP_LS, C_DISP_LS, 8'h00);
            run_cmd(8'h01 << C_DISP_MS, C_DISP_MS, 8'h00);
            run_cmd(8'h01 << C_DISP_A, C_DISP_A, 8'h00);
        end

        // Priority: LOAD_A beats DISPLAY_B; multi-request priority INIT over everything.
        run_cmd((8'h01 << C_LOAD_A) | (8'h01 << C_DISP_B), C_LOAD_A, 8'h36);
        run_cmd((8'h01 << C_DISP_LS) | (8'h01 << C_DISP_MS), C_DISP_MS, 8'h00);
        run_cmd((8'h01 << C_ADD) | (8'h01 << C_DISP_A), C_ADD, 8'h00);
        run_cmd(8'h01 << C_DISP_A, C_DISP_A, 8'h00);

        // Request dropped before its acknowledge: one-cycle acknowledge pulse.
        @(negedge CLK);
        req = 8'h01 << C_DISP_B;
        model_cmd(C_DISP_B, 8'h00);
        @(negedge CLK);
        req = 8'h00;
        @(posedge CLK); #1;
        check("pulse_ack_hi", ack, 8'h01 << C_DISP_B);
        check("pulse_disp", DISP, exp_q.pop_front());
        @(posedge CLK); #1;
        check("pulse_ack_lo", ack, 8'h00);

        // Invalid digits on load.
        run_cmd(8'h01 << C_LOAD_A, C_LOAD_A, 8'hA3);
        run_cmd(8'h01 << C_DISP_A, C_DISP_A, 8'h00);
        run_cmd(8'h01 << C_INIT, C_INIT, 8'h00);
        run_cmd(8'h01 << C_DISP_A, C_DISP_A, 8'h00);

        // Reset in the middle of an ADD.
        run_cmd(8'h01 << C_LOAD_A, C_LOAD_A, 8'h99);
        run_cmd(8'h01 << C_LOAD_B, C_LOAD_B, 8'h99);
        run_cmd(8'h01 << C_ADD, C_ADD, 8'h00);
        run_cmd(8'h01 << C_DISP_LS, C_DISP_LS, 8'h00);
        @(negedge CLK);
        req = 8'h01 << C_ADD;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        #1;
        check("midrst_ack", ack, 8'h00);
        check("midrst_disp", DISP, 8'h00);
        check("midrst_err", ERR, 1'b0);
        @(negedge CLK);
        req = 8'h00;
        @(negedge CLK);
        RST_N = 1'b1;
        a_m = 0; b_m = 0; r_m = 0; disp_m = 0; err_m = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            check("midrst_no_ack", ack, 8'h00);
        end
        run_cmd(8'h01 << C_DISP_MS, C_DISP_MS, 8'h00);
        run_cmd(8'h01 << C_DISP_A, C_DISP_A, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
